memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_memory_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: pipeline memory stage between execute and writeback.
// Issues LD/ST/STU data-memory requests and stalls the front of the pipe
// while an access is outstanding. A WAIT timeout lands in a sticky ERR
// state that only reset clears.
// Build option: define MEM_ALIGN_CHECK_EN to turn an odd-address memory op
// into an immediate error instead of a memory access.
module memory_stage #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] instruction_in,
  input  logic [15:0] Xcomp_in,
  input  logic [15:0] RegData_in,
  input  logic [15:0] incrPC_in,
  input  logic        RegWrt_in,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        stall_out,
  output logic [15:0] instruction_out,
  output logic [15:0] MemData_out,
  output logic [15:0] Xcomp_out,
  output logic [15:0] incrPC_out,
  output logic        RegWrt_out,
  output logic        valid_out,
  output logic        err_out
);

  localparam logic [4:0] OP_ST  = 5'b10000;
  localparam logic [4:0] OP_LD  = 5'b10001;
  localparam logic [4:0] OP_STU = 5'b10011;

  // Last counter value that may still be spent waiting; the WAIT state
  // therefore lasts exactly TIMEOUT_CYC cycles before ERR.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR
  } state_t;

  // What the writeback registers load at the next edge.
  typedef enum logic [1:0] {
    WB_PASS,
    WB_ISSUE_DONE,
    WB_HOLD_DONE,
    WB_BUBBLE
  } wb_sel_t;

  state_t      state;
  state_t      state_next;
  wb_sel_t     wb_sel;

  logic [4:0]  opcode;
  logic        in_is_ld;
  logic        in_is_wr;
  logic        in_req;
  logic        in_misaligned;

  logic        hold_load;
  logic        cnt_clr;
  logic        cnt_inc;
  logic [7:0]  wait_cnt;

  logic [15:0] hold_instr;
  logic [15:0] hold_addr;
  logic [15:0] hold_wdata;
  logic [15:0] hold_pc;
  logic        hold_regwrt;
  logic        hold_is_ld;
  logic        hold_is_wr;

  assign opcode   = instruction_in[15:11];
  assign in_is_ld = (opcode == OP_LD);
  assign in_is_wr = (opcode == OP_ST) || (opcode == OP_STU);
  assign in_req   = valid_in && (in_is_ld || in_is_wr);

`ifdef MEM_ALIGN_CHECK_EN
  assign in_misaligned = Xcomp_in[0];
`else
  assign in_misaligned = 1'b0;
`endif

  // State register for the access-control FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, memory request, stall and writeback selection.
  always_comb begin
    state_next = state;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = 16'h0000;
    stall_out  = 1'b0;
    wb_sel     = WB_BUBBLE;
    hold_load  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (in_req) begin
          if (in_misaligned) begin
            stall_out  = 1'b1;
            state_next = ST_ERR;
          end else begin
            mem_en    = 1'b1;
            mem_wr    = in_is_wr;
            mem_addr  = Xcomp_in;
            mem_wdata = RegData_in;
            if (mem_done) begin
              wb_sel = WB_ISSUE_DONE;
            end else begin
              stall_out  = 1'b1;
              hold_load  = 1'b1;
              cnt_clr    = 1'b1;
              state_next = ST_WAIT;
            end
          end
        end else begin
          wb_sel = WB_PASS;
        end
      end

      ST_WAIT: begin
        mem_en    = 1'b1;
        mem_wr    = hold_is_wr;
        mem_addr  = hold_addr;
        mem_wdata = hold_wdata;
        if (mem_done) begin
          wb_sel     = WB_HOLD_DONE;
          state_next = ST_IDLE;
        end else begin
          stall_out = 1'b1;
          if (wait_cnt == TIMEOUT_LAST) begin
            state_next = ST_ERR;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end

      ST_ERR: begin
        stall_out = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Cycles already spent in WAIT for the outstanding access.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 8'h00;
    end else if (cnt_clr) begin
      wait_cnt <= 8'h00;
    end else if (cnt_inc) begin
      wait_cnt <= wait_cnt + 8'h01;
    end
  end

  // Snapshot of the stalled instruction so the *_in ports can be ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_instr  <= 16'h0000;
      hold_addr   <= 16'h0000;
      hold_wdata  <= 16'h0000;
      hold_pc     <= 16'h0000;
      hold_regwrt <= 1'b0;
      hold_is_ld  <= 1'b0;
      hold_is_wr  <= 1'b0;
    end else if (hold_load) begin
      hold_instr  <= instruction_in;
      hold_addr   <= Xcomp_in;
      hold_wdata  <= RegData_in;
      hold_pc     <= incrPC_in;
      hold_regwrt <= RegWrt_in;
      hold_is_ld  <= in_is_ld;
      hold_is_wr  <= in_is_wr;
    end
  end

  // Sticky error flag, set on every edge that leaves the FSM in ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_out <= 1'b0;
    end else if (state_next == ST_ERR) begin
      err_out <= 1'b1;
    end
  end

  // Writeback pipe register; bubbles are all-zero so nothing is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction_out <= 16'h0000;
      MemData_out     <= 16'h0000;
      Xcomp_out       <= 16'h0000;
      incrPC_out      <= 16'h0000;
      RegWrt_out      <= 1'b0;
      valid_out       <= 1'b0;
    end else begin
      case (wb_sel)
        WB_PASS: begin
          instruction_out <= instruction_in;
          MemData_out     <= 16'h0000;
          Xcomp_out       <= Xcomp_in;
          incrPC_out      <= incrPC_in;
          RegWrt_out      <= RegWrt_in;
          valid_out       <= valid_in;
        end
        WB_ISSUE_DONE: begin
          instruction_out <= instruction_in;
          MemData_out     <= in_is_ld ? mem_rdata : 16'h0000;
          Xcomp_out       <= Xcomp_in;
          incrPC_out      <= incrPC_in;
          RegWrt_out      <= RegWrt_in;
          valid_out       <= 1'b1;
        end
        WB_HOLD_DONE: begin
          instruction_out <= hold_instr;
          MemData_out     <= hold_is_ld ? mem_rdata : 16'h0000;
          Xcomp_out       <= hold_addr;
          incrPC_out      <= hold_pc;
          RegWrt_out      <= hold_regwrt;
          valid_out       <= 1'b1;
        end
        default: begin
          instruction_out <= 16'h0000;
          MemData_out     <= 16'h0000;
          Xcomp_out       <= 16'h0000;
          incrPC_out      <= 16'h0000;
          RegWrt_out      <= 1'b0;
          valid_out       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: self-checking bench for memory_stage.
// Honours MEM_ALIGN_CHECK_EN the same way the design does.
module tb_memory_stage;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] instruction_in;
  logic [15:0] Xcomp_in;
  logic [15:0] RegData_in;
  logic [15:0] incrPC_in;
  logic        RegWrt_in;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        stall_out;
  logic [15:0] instruction_out;
  logic [15:0] MemData_out;
  logic [15:0] Xcomp_out;
  logic [15:0] incrPC_out;
  logic        RegWrt_out;
  logic        valid_out;
  logic        err_out;

  memory_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .instruction_in(instruction_in),
    .Xcomp_in(Xcomp_in), .RegData_in(RegData_in), .incrPC_in(incrPC_in),
    .RegWrt_in(RegWrt_in), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_out(stall_out), .instruction_out(instruction_out),
    .MemData_out(MemData_out), .Xcomp_out(Xcomp_out), .incrPC_out(incrPC_out),
    .RegWrt_out(RegWrt_out), .valid_out(valid_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: one outstanding access, how long it has waited,
  // a sticky error, and the writeback values the stage should present.
  bit          m_err = 1'b0;
  bit          m_pend = 1'b0;
  int          m_waited = 0;
  logic [15:0] h_instr = '0, h_addr = '0, h_wdata = '0, h_pc = '0;
  bit          h_rw = 1'b0, h_ld = 1'b0, h_wr = 1'b0;
  logic [15:0] e_instr = '0, e_mdata = '0, e_x = '0, e_pc = '0;
  bit          e_rw = 1'b0, e_valid = 1'b0, e_err = 1'b0;

  // Mid-cycle samples of the combinational outputs.
  logic        c_en, c_wr, c_stall;
  logic [15:0] c_addr, c_wdata;

  typedef struct {
    logic        valid;
    logic [15:0] instr;
    logic [15:0] x;
    logic [15:0] d;
    logic [15:0] pc;
    logic        rw;
    logic [15:0] rdata;
    logic        done;
    logic        exp_en;
    logic        exp_wr;
    logic        exp_stall;
    logic [15:0] exp_mdata;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[6];

  function automatic bit isMem(input logic [15:0] i);
    return (i[15:11] == 5'b10001) || (i[15:11] == 5'b10000) || (i[15:11] == 5'b10011);
  endfunction

  function automatic bit misaligned(input logic [15:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return a[0];
`else
    return (a != a);
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] instr, input logic [15:0] x,
                               input logic [15:0] d, input logic [15:0] pc, input logic rw,
                               input logic [15:0] rdata, input logic done, input logic r);
    valid_in       = v;
    instruction_in = instr;
    Xcomp_in       = x;
    RegData_in     = d;
    incrPC_in      = pc;
    RegWrt_in      = rw;
    mem_rdata      = rdata;
    mem_done       = done;
    rst            = r;
  endtask

  task automatic clearExpected();
    e_instr = '0; e_mdata = '0; e_x = '0; e_pc = '0; e_rw = 1'b0; e_valid = 1'b0;
  endtask

  // One clock: check the request side mid-cycle, advance the model at the
  // edge, then check the writeback side just after the edge.
  task automatic runCycle();
    bit x_en, x_wr, x_stall;
    logic [15:0] x_addr, x_wdata;
    x_en = 1'b0; x_wr = 1'b0; x_stall = 1'b0; x_addr = '0; x_wdata = '0;
    if (m_err) begin
      x_stall = 1'b1;
    end else if (m_pend) begin
      x_en = 1'b1; x_wr = h_wr; x_addr = h_addr; x_wdata = h_wdata; x_stall = !mem_done;
    end else if (valid_in && isMem(instruction_in)) begin
      if (misaligned(Xcomp_in)) begin
        x_stall = 1'b1;
      end else begin
        x_en = 1'b1; x_wr = (instruction_in[15:11] != 5'b10001);
        x_addr = Xcomp_in; x_wdata = RegData_in; x_stall = !mem_done;
      end
    end
    #3;
    c_en = mem_en; c_wr = mem_wr; c_stall = stall_out; c_addr = mem_addr; c_wdata = mem_wdata;
    checkOutput("mem_en", 16'(mem_en), 16'(x_en));
    checkOutput("stall_out", 16'(stall_out), 16'(x_stall));
    if (x_en) begin
      checkOutput("mem_wr", 16'(mem_wr), 16'(x_wr));
      checkOutput("mem_addr", mem_addr, x_addr);
      checkOutput("mem_wdata", mem_wdata, x_wdata);
    end
    @(posedge clk);
    if (rst) begin
      m_err = 1'b0; m_pend = 1'b0; m_waited = 0; e_err = 1'b0;
      clearExpected();
    end else if (m_err) begin
      clearExpected();
    end else if (m_pend) begin
      if (mem_done) begin
        e_instr = h_instr; e_x = h_addr; e_pc = h_pc; e_rw = h_rw; e_valid = 1'b1;
        e_mdata = h_ld ? mem_rdata : 16'h0000;
        m_pend = 1'b0;
      end else begin
        clearExpected();
        m_waited++;
        if (m_waited == TO) begin
          m_err = 1'b1; m_pend = 1'b0; e_err = 1'b1;
        end
      end
    end else if (valid_in && isMem(instruction_in)) begin
      if (misaligned(Xcomp_in)) begin
        clearExpected();
        m_err = 1'b1; e_err = 1'b1;
      end else if (mem_done) begin
        e_instr = instruction_in; e_x = Xcomp_in; e_pc = incrPC_in; e_rw = RegWrt_in;
        e_valid = 1'b1;
        e_mdata = (instruction_in[15:11] == 5'b10001) ? mem_rdata : 16'h0000;
      end else begin
        clearExpected();
        m_pend = 1'b1; m_waited = 0;
        h_instr = instruction_in; h_addr = Xcomp_in; h_wdata = RegData_in;
        h_pc = incrPC_in; h_rw = RegWrt_in;
        h_ld = (instruction_in[15:11] == 5'b10001);
        h_wr = !h_ld;
      end
    end else begin
      e_instr = instruction_in; e_x = Xcomp_in; e_pc = incrPC_in; e_rw = RegWrt_in;
      e_valid = valid_in; e_mdata = 16'h0000;
    end
    #1;
    checkOutput("instruction_out", instruction_out, e_instr);
    checkOutput("MemData_out", MemData_out, e_mdata);
    checkOutput("Xcomp_out", Xcomp_out, e_x);
    checkOutput("incrPC_out", incrPC_out, e_pc);
    checkOutput("RegWrt_out", 16'(RegWrt_out), 16'(e_rw));
    checkOutput("valid_out", 16'(valid_out), 16'(e_valid));
    checkOutput("err_out", 16'(err_out), 16'(e_err));
  endtask

  // Watchdog so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stall_cnt;
    vecs[0] = '{1'b1, 16'h8800, 16'h0040, 16'h5555, 16'h0102, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF, 1'b1};
    vecs[1] = '{1'b1, 16'h8000, 16'h0010, 16'h1234, 16'h0104, 1'b0, 16'hAAAA, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{1'b1, 16'h9800, 16'h0022, 16'h4321, 16'h0106, 1'b1, 16'h7777, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{1'b1, 16'hD801, 16'h0007, 16'h0000, 16'h0108, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{1'b0, 16'h8800, 16'h0050, 16'h0000, 16'h010A, 1'b1, 16'hCAFE, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{1'b1, 16'h9000, 16'h0060, 16'h1111, 16'h010C, 1'b0, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};

    // Bring the design out of its unknown power-up state.
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
    @(posedge clk); #1;
    runCycle();
    checkOutput("reset instruction_out", instruction_out, 16'h0000);
    checkOutput("reset valid_out", 16'(valid_out), 16'h0000);
    checkOutput("reset err_out", 16'(err_out), 16'h0000);

    // Single-cycle cases from IDLE.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].instr, vecs[i].x, vecs[i].d, vecs[i].pc,
                    vecs[i].rw, vecs[i].rdata, vecs[i].done, 1'b0);
      runCycle();
      checkOutput($sformatf("vec%0d mem_en", i), 16'(c_en), 16'(vecs[i].exp_en));
      checkOutput($sformatf("vec%0d stall", i), 16'(c_stall), 16'(vecs[i].exp_stall));
      if (vecs[i].exp_en)
        checkOutput($sformatf("vec%0d mem_wr", i), 16'(c_wr), 16'(vecs[i].exp_wr));
      checkOutput($sformatf("vec%0d MemData", i), MemData_out, vecs[i].exp_mdata);
      checkOutput($sformatf("vec%0d valid", i), 16'(valid_out), 16'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d Xcomp", i), Xcomp_out, vecs[i].x);
      checkOutput($sformatf("vec%0d instr", i), instruction_out, vecs[i].instr);
      checkOutput($sformatf("vec%0d incrPC", i), incrPC_out, vecs[i].pc);
      checkOutput($sformatf("vec%0d RegWrt", i), 16'(RegWrt_out), 16'(vecs[i].rw));
    end

    // Store that completes three cycles after issue; inputs change meanwhile.
    applyStimulus(1'b1, 16'h8000, 16'h0010, 16'h1234, 16'h0200, 1'b0, 16'h0000, 1'b0, 1'b0);
    runCycle();
    checkOutput("st issue stall", 16'(c_stall), 16'h0001);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 16'h8801, 16'h0F0E, 16'hDEAD, 16'h0300, 1'b1, 16'h5A5A, 1'b0, 1'b0);
      runCycle();
      checkOutput("st wait stall", 16'(c_stall), 16'h0001);
      checkOutput("st wait mem_wr", 16'(c_wr), 16'h0001);
      checkOutput("st wait addr", c_addr, 16'h0010);
      checkOutput("st wait wdata", c_wdata, 16'h1234);
      checkOutput("st wait valid_out", 16'(valid_out), 16'h0000);
    end
    applyStimulus(1'b1, 16'h8801, 16'h0F0E, 16'hDEAD, 16'h0300, 1'b1, 16'h5A5A, 1'b1, 1'b0);
    runCycle();
    checkOutput("st done stall", 16'(c_stall), 16'h0000);
    checkOutput("st done valid_out", 16'(valid_out), 16'h0001);
    checkOutput("st done Xcomp_out", Xcomp_out, 16'h0010);
    checkOutput("st done MemData", MemData_out, 16'h0000);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    runCycle();
    checkOutput("st valid pulse", 16'(valid_out), 16'h0000);

    // Load that never completes: timeout into ERR, then reset.
    applyStimulus(1'b1, 16'h8800, 16'h0100, 16'h0000, 16'h0400, 1'b1, 16'h0000, 1'b0, 1'b0);
    runCycle();
    stall_cnt = 0;
    for (int i = 0; i < TO; i++) begin
      applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      runCycle();
      if (c_stall) stall_cnt++;
      if (i == TO - 2) checkOutput("timeout err early", 16'(err_out), 16'h0000);
    end
    checkOutput("timeout stall count", 16'(stall_cnt), 16'(TO));
    checkOutput("timeout err_out", 16'(err_out), 16'h0001);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'h8800, 16'h0044, 16'h0000, 16'h0000, 1'b1, 16'h1357, 1'b1, 1'b0);
      runCycle();
      checkOutput("err mem_en", 16'(c_en), 16'h0000);
      checkOutput("err stall", 16'(c_stall), 16'h0001);
      checkOutput("err sticky", 16'(err_out), 16'h0001);
      checkOutput("err valid_out", 16'(valid_out), 16'h0000);
    end
    applyStimulus(1'b1, 16'h8800, 16'h0044, 16'h0000, 16'h0000, 1'b1, 16'h1357, 1'b1, 1'b1);
    runCycle();
    checkOutput("post-err reset err_out", 16'(err_out), 16'h0000);
    checkOutput("post-err reset RegWrt", 16'(RegWrt_out), 16'h0000);
    checkOutput("post-err reset instr", instruction_out, 16'h0000);

    // Reset on the second WAIT cycle aborts the load.
    applyStimulus(1'b1, 16'h8800, 16'h0200, 16'h0000, 16'h0500, 1'b1, 16'h0000, 1'b0, 1'b0);
    runCycle();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    runCycle();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    runCycle();
    applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'hFACE, 1'b1, 1'b0);
    runCycle();
    checkOutput("abort mem_en", 16'(c_en), 16'h0000);
    checkOutput("abort valid_out", 16'(valid_out), 16'h0000);
    checkOutput("abort MemData", MemData_out, 16'h0000);

    // Odd-address load.
    applyStimulus(1'b1, 16'h8800, 16'h0041, 16'h0000, 16'h0600, 1'b1, 16'h1111, 1'b1, 1'b0);
    runCycle();
`ifdef MEM_ALIGN_CHECK_EN
    checkOutput("align mem_en", 16'(c_en), 16'h0000);
    checkOutput("align err_out", 16'(err_out), 16'h0001);
    applyStimulus(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    runCycle();
`else
    checkOutput("align mem_en", 16'(c_en), 16'h0001);
    checkOutput("align addr", c_addr, 16'h0041);
    checkOutput("align MemData", MemData_out, 16'h1111);
    checkOutput("align err_out", 16'(err_out), 16'h0000);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  op;
      logic [15:0] a;
      logic        r;
      case ($urandom_range(0, 4))
        0: op = 5'b10001;
        1: op = 5'b10000;
        2: op = 5'b10011;
        default: op = 5'($urandom);
      endcase
      a = 16'($urandom);
      if ($urandom_range(0, 7) != 0) a[0] = 1'b0;
      r = m_err || ($urandom_range(0, 63) == 0);
      applyStimulus($urandom_range(0, 3) != 0, {op, 11'($urandom)}, a, 16'($urandom),
                    16'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, 2) != 0, r);
      runCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
